icache_refill_ctrl: RTL

//  Sequences line refills from the slow instruction ROM into the I-cache on a fetch miss.

---
 rtl/icache_refill_ctrl_pkg.sv | 17 +
 rtl/icache_refill_ctrl_if.sv | 37 +++
 rtl/icache_refill_ctrl_sat_counter.sv | 26 ++
 rtl/icache_refill_ctrl.sv | 117 +++++++++++
 4 files changed

// File: rtl/icache_refill_ctrl_pkg.sv
// Shared I-cache definitions: refill FSM encodings and default geometry.
package riscv_cache_pkg;

  localparam int ADDR_W      = 8;
  localparam int DATA_W      = 32;
  localparam int LINE_WORDS  = 4;
  localparam int LINE_OFF_W  = $clog2(LINE_WORDS);
  localparam int MEM_LATENCY = 2;
  localparam int CNT_W       = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } refill_state_e;

endpackage

// File: rtl/icache_refill_ctrl_if.sv
// Bundle between fetch stage / I-cache / instruction ROM and the refill controller.
interface icache_refill_ctrl_if #(
  parameter int ADDR_W = riscv_cache_pkg::ADDR_W,
  parameter int DATA_W = riscv_cache_pkg::DATA_W,
  parameter int OFF_W  = riscv_cache_pkg::LINE_OFF_W,
  parameter int CNT_W  = riscv_cache_pkg::CNT_W
);

  logic              miss_valid;
  logic [ADDR_W-1:0] miss_addr;
  logic              miss_ready;
  logic              flush;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              fill_we;
  logic [OFF_W-1:0]  fill_word_idx;
  logic [DATA_W-1:0] fill_data;
  logic              fill_tag_we;
  logic              fill_done;
  logic              stall;
  logic [CNT_W-1:0]  refill_cnt;

  // Fetch stage, ROM and cache array side
  modport master (
    output miss_valid, miss_addr, flush, mem_rdata,
    input  miss_ready, mem_addr, fill_we, fill_word_idx, fill_data,
           fill_tag_we, fill_done, stall, refill_cnt
  );

  // Refill controller side
  modport slave (
    input  miss_valid, miss_addr, flush, mem_rdata,
    output miss_ready, mem_addr, fill_we, fill_word_idx, fill_data,
           fill_tag_we, fill_done, stall, refill_cnt
  );

endinterface

// File: rtl/icache_refill_ctrl_sat_counter.sv
// Saturating event counter: increments on inc, sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_r;

  // Count events, holding once the counter is full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {W{1'b0}};
    end else if (inc && (count_r != {W{1'b1}})) begin
      count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/icache_refill_ctrl.sv
// I-cache line refill sequencer: on a fetch miss reads a whole line from the
// slow instruction ROM word by word, streams it into the data array, then
// writes the tag. The fetch stage is stalled while a refill is in flight.
module icache_refill_ctrl #(
  parameter int ADDR_W      = riscv_cache_pkg::ADDR_W,
  parameter int DATA_W      = riscv_cache_pkg::DATA_W,
  parameter int LINE_WORDS  = riscv_cache_pkg::LINE_WORDS,
  parameter int MEM_LATENCY = riscv_cache_pkg::MEM_LATENCY,
  parameter int CNT_W       = riscv_cache_pkg::CNT_W
) (
  input logic                 clk,
  input logic                 rst_n,
  icache_refill_ctrl_if.slave bus
);

  import riscv_cache_pkg::*;

  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int WAIT_W = (MEM_LATENCY > 0) ? $clog2(MEM_LATENCY + 1) : 1;
  localparam logic [OFF_W-1:0]  LAST_IDX  = OFF_W'(LINE_WORDS - 1);
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(MEM_LATENCY);
  localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'(LINE_WORDS - 1);

  refill_state_e     state_r;
  logic [ADDR_W-1:0] base_r;
  logic [OFF_W-1:0]  word_cnt_r;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] fill_data_r;
  logic [OFF_W-1:0]  fill_idx_r;
  logic              fill_we_r;
  logic              done_r;
  logic [ADDR_W-1:0] line_base_s;
  logic [ADDR_W-1:0] next_addr_s;
  logic [CNT_W-1:0]  cnt_s;

  // Line-aligned base of the missing address, and the next word inside the line.
  // The word counter only advances below the last index, so the OR never leaves the line.
  assign line_base_s = bus.miss_addr & ~OFF_MASK;
  assign next_addr_s = base_r | ADDR_W'(word_cnt_r + OFF_W'(1));

  // Refill FSM with wait/word counters; flush aborts from any state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      base_r      <= {ADDR_W{1'b0}};
      word_cnt_r  <= {OFF_W{1'b0}};
      wait_cnt_r  <= {WAIT_W{1'b0}};
      mem_addr_r  <= {ADDR_W{1'b0}};
      fill_data_r <= {DATA_W{1'b0}};
      fill_idx_r  <= {OFF_W{1'b0}};
      fill_we_r   <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      fill_we_r <= 1'b0;
      done_r    <= 1'b0;
      if (bus.flush) begin
        state_r <= ST_IDLE;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (bus.miss_valid) begin
              base_r     <= line_base_s;
              mem_addr_r <= line_base_s;
              word_cnt_r <= {OFF_W{1'b0}};
              wait_cnt_r <= WAIT_INIT;
              state_r    <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (wait_cnt_r != {WAIT_W{1'b0}}) begin
              wait_cnt_r <= wait_cnt_r - WAIT_W'(1);
            end else begin
              fill_data_r <= bus.mem_rdata;
              fill_idx_r  <= word_cnt_r;
              fill_we_r   <= 1'b1;
              if (word_cnt_r == LAST_IDX) begin
                done_r  <= 1'b1;
                state_r <= ST_DONE;
              end else begin
                word_cnt_r <= word_cnt_r + OFF_W'(1);
                wait_cnt_r <= WAIT_INIT;
                mem_addr_r <= next_addr_s;
              end
            end
          end
          ST_DONE: begin
            state_r <= ST_IDLE;
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Completed-line counter; a line only reaches DONE if it was never flushed
  sat_counter #(.W(CNT_W)) u_refill_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (state_r == ST_DONE),
    .count (cnt_s)
  );

  // Handshake and stall are combinational so the PC freezes in the miss cycle itself
  assign bus.miss_ready    = (state_r == ST_IDLE) & ~bus.flush;
  assign bus.stall         = (state_r != ST_IDLE) | ((state_r == ST_IDLE) & bus.miss_valid);
  assign bus.mem_addr      = mem_addr_r;
  assign bus.fill_we       = fill_we_r;
  assign bus.fill_word_idx = fill_idx_r;
  assign bus.fill_data     = fill_data_r;
  assign bus.fill_tag_we   = done_r;
  assign bus.fill_done     = done_r;
  assign bus.refill_cnt    = cnt_s;

endmodule
